decoder_3to8_seq: RTL and testbench

DECODER_3TO8_SEQ -- requirements
Module: decoder_3to8_seq

---
 rtl/decoder_3to8_seq.sv | 147 ++++++++++++++
 tb/tb_decoder_3to8_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_3to8_seq.sv
// ---------------------------------------------------------------------------
// decoder_3to8_seq
//   Queues 3-bit codes in a 4-entry FIFO and presents each one, decoded to a
//   one-hot byte, on Y for HOLD_CYCLES clock cycles. Queued codes follow one
//   another back-to-back. The output returns to all-zero only when the FIFO
//   runs dry.
//
// Parameters
//   HOLD_CYCLES : cycles each decoded word stays on Y (1..255)
//   DEPTH       : FIFO entries (fixed at 4; pointers are 2 bits)
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   synchronous active-low reset
//   A[2:0]     in   code to decode (bit 2 = MSB)
//   a_valid    in   A carries a code offered for acceptance
//   a_ready    out  the FIFO has room (registered, independent of a_valid)
//   Y[7:0]     out  registered decoded word, one-hot or zero
//   y_valid    out  Y carries a decoded word
//   fifo_count out  codes queued and not yet decoded (0..4)
//   state_dbg  out  current FSM state (0 = IDLE, 1 = HOLD)
//
// Handshake: a code transfers on a rising edge where a_valid and a_ready are
// both 1. a_ready depends only on the registered fifo_count. A pop in the
// same cycle therefore never opens room for a push into a full FIFO. The
// producer holds A stable until that edge.
// ---------------------------------------------------------------------------
module decoder_3to8_seq #(
    parameter int HOLD_CYCLES = 4,
    parameter int DEPTH       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] A,
    input  logic       a_valid,
    output logic       a_ready,
    output logic [7:0] Y,
    output logic       y_valid,
    output logic [2:0] fifo_count,
    output logic       state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [2:0] FULL_CNT  = 3'(DEPTH);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] hold_cnt;
    logic [7:0] hold_nxt;
    logic [7:0] y_nxt;
    logic       yv_nxt;

    logic [2:0] mem [DEPTH];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       push;
    logic       pop;

    assign a_ready    = (count != FULL_CNT);
    assign push       = a_valid && a_ready;
    assign fifo_count = count;
    assign state_dbg  = state;

    // Next-state and output decode. Y and y_valid are registered, so every
    // branch describes what they become after the coming edge.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        y_nxt     = Y;
        yv_nxt    = y_valid;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (count != 3'd0) begin
                    pop       = 1'b1;
                    y_nxt     = 8'd1 << mem[rd_ptr];
                    yv_nxt    = 1'b1;
                    hold_nxt  = HOLD_LOAD;
                    state_nxt = HOLD;
                end else begin
                    y_nxt  = 8'h00;
                    yv_nxt = 1'b0;
                end
            end
            HOLD: begin
                if (hold_cnt != 8'd0) begin
                    hold_nxt = hold_cnt - 8'd1;
                end else if (count != 3'd0) begin
                    // Reload on the same edge so the queue drains gap-free.
                    pop      = 1'b1;
                    y_nxt    = 8'd1 << mem[rd_ptr];
                    yv_nxt   = 1'b1;
                    hold_nxt = HOLD_LOAD;
                end else begin
                    y_nxt     = 8'h00;
                    yv_nxt    = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                y_nxt     = 8'h00;
                yv_nxt    = 1'b0;
                hold_nxt  = 8'd0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= 8'd0;
            Y        <= 8'h00;
            y_valid  <= 1'b0;
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            Y        <= y_nxt;
            y_valid  <= yv_nxt;
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            // A simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= A;
        end
    end

endmodule

// File: tb/tb_decoder_3to8_seq.sv
// ---------------------------------------------------------------------------
// tb_decoder_3to8_seq
//   Three instances share one clock: u4 (HOLD_CYCLES=4), u1 (HOLD_CYCLES=1)
//   and u8 (HOLD_CYCLES=8). Directed steps run in one initial block. Inputs
//   change 1 time unit after a rising edge, and outputs are checked at the
//   same point. A negedge monitor checks the invariants of all three
//   instances. It also tracks the word order and span length on u4 against
//   the queue exp_q.
// ---------------------------------------------------------------------------
module tb_decoder_3to8_seq;

    localparam int HOLD4 = 4;

    logic       clk;
    logic       rst_n;
    logic       rst4_n;

    logic [2:0] a4, a1, a8;
    logic       av4, av1, av8;
    logic       ready4, ready1, ready8;
    logic [7:0] y4, y1, y8;
    logic       yv4, yv1, yv8;
    logic [2:0] cnt4, cnt1, cnt8;
    logic       st4, st1, st8;

    int         n_cmp = 0;
    int         n_err = 0;
    logic       mon_en = 1'b0;
    logic [7:0] exp_q[$];
    int         words_seen = 0;
    int         run = 0;
    logic       prev_v = 1'b0;
    logic [7:0] prev_y = 8'h00;

    decoder_3to8_seq #(.HOLD_CYCLES(4), .DEPTH(4)) u4 (
        .clk(clk), .rst_n(rst4_n), .A(a4), .a_valid(av4), .a_ready(ready4),
        .Y(y4), .y_valid(yv4), .fifo_count(cnt4), .state_dbg(st4));

    decoder_3to8_seq #(.HOLD_CYCLES(1), .DEPTH(4)) u1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .a_valid(av1), .a_ready(ready1),
        .Y(y1), .y_valid(yv1), .fifo_count(cnt1), .state_dbg(st1));

    decoder_3to8_seq #(.HOLD_CYCLES(8), .DEPTH(4)) u8 (
        .clk(clk), .rst_n(rst_n), .A(a8), .a_valid(av8), .a_ready(ready8),
        .Y(y8), .y_valid(yv8), .fifo_count(cnt8), .state_dbg(st8));

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic inv(input string tag, input logic [7:0] y, input logic yv,
                       input logic [2:0] cnt, input logic rdy);
        chk({tag, "_onehot0"}, 32'($onehot0(y)), 32'd1);
        chk({tag, "_yvalid_vs_y"}, 32'(yv), 32'(y != 8'h00));
        chk({tag, "_count_range"}, 32'(cnt <= 3'd4), 32'd1);
        chk({tag, "_ready_vs_count"}, 32'(rdy), 32'(cnt != 3'd4));
    endtask

    // ---------------- per-cycle monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            inv("u4", y4, yv4, cnt4, ready4);
            inv("u1", y1, yv1, cnt1, ready1);
            inv("u8", y8, yv8, cnt8, ready8);
            if (!rst4_n) begin
                run    = 0;
                prev_v = 1'b0;
                prev_y = 8'h00;
            end else begin
                logic start;
                start = yv4 && (!prev_v || (y4 != prev_y) || (run == HOLD4));
                if (prev_v && (!yv4 || start))
                    chk("u4_span_len", 32'(run), 32'(HOLD4));
                if (start) begin
                    if (exp_q.size() == 0) begin
                        chk("u4_unexpected_word", 32'(y4), 32'h0);
                    end else begin
                        chk("u4_word_order", 32'(y4), 32'(exp_q.pop_front()));
                        words_seen++;
                    end
                    run = 1;
                end else if (yv4) begin
                    run++;
                end else begin
                    run = 0;
                end
                prev_v = yv4;
                prev_y = y4;
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int codes[10];
        int wait_cnt;
        codes = '{0, 1, 2, 3, 4, 5, 6, 7, 1, 2};

        rst_n = 1'b0; rst4_n = 1'b0;
        a4 = 3'd0; a1 = 3'd0; a8 = 3'd0;
        av4 = 1'b0; av1 = 1'b0; av8 = 1'b0;

        // Reset state
        step(2);
        chk("rst_y4", 32'(y4), 32'h0);
        chk("rst_yv4", 32'(yv4), 32'h0);
        chk("rst_cnt4", 32'(cnt4), 32'h0);
        chk("rst_ready4", 32'(ready4), 32'h1);
        chk("rst_state4", 32'(st4), 32'h0);
        chk("rst_cnt1", 32'(cnt1), 32'h0);
        chk("rst_cnt8", 32'(cnt8), 32'h0);
        rst_n = 1'b1; rst4_n = 1'b1;
        mon_en = 1'b1;

        // Single code 5 on u4, hold 4
        a4 = 3'd5; av4 = 1'b1;
        exp_q.push_back(8'h20);
        step(1);                     // edge 0: accepted
        av4 = 1'b0;
        chk("single_cnt_e0", 32'(cnt4), 32'd1);
        chk("single_yv_e0", 32'(yv4), 32'd0);
        for (int e = 1; e <= 4; e++) begin
            step(1);
            chk("single_y_hold", 32'(y4), 32'h20);
            chk("single_yv_hold", 32'(yv4), 32'd1);
        end
        step(1);                     // edge 5
        chk("single_y_end", 32'(y4), 32'h00);
        chk("single_yv_end", 32'(yv4), 32'd0);
        chk("single_state_end", 32'(st4), 32'd0);

        // Back-to-back 0,7,3 on u1, hold 1
        av1 = 1'b1; a1 = 3'd0; step(1);
        a1 = 3'd7; step(1);
        chk("b2b_y1", 32'(y1), 32'h01);
        a1 = 3'd3; step(1);
        av1 = 1'b0;
        chk("b2b_y2", 32'(y1), 32'h80);
        step(1);
        chk("b2b_y3", 32'(y1), 32'h08);
        step(1);
        chk("b2b_y4", 32'(y1), 32'h00);
        chk("b2b_yv4", 32'(yv1), 32'd0);

        // Full FIFO on u8, hold 8, a_valid held high
        av8 = 1'b1;
        a8 = 3'd1; step(1);          // e0 push 1
        a8 = 3'd2; step(1);          // e1 push 2, pop 1
        chk("full_y_e1", 32'(y8), 32'h02);
        chk("full_cnt_e1", 32'(cnt8), 32'd1);
        a8 = 3'd3; step(1);
        a8 = 3'd4; step(1);
        a8 = 3'd5; step(1);          // e4: four queued
        chk("full_cnt_e4", 32'(cnt8), 32'd4);
        chk("full_ready_e4", 32'(ready8), 32'd0);
        a8 = 3'd6; step(4);          // e8: still stalled
        chk("full_cnt_e8", 32'(cnt8), 32'd4);
        chk("full_ready_e8", 32'(ready8), 32'd0);
        chk("full_y_e8", 32'(y8), 32'h02);
        step(1);                     // e9: pop from full, no push
        chk("full_cnt_e9", 32'(cnt8), 32'd3);
        chk("full_y_e9", 32'(y8), 32'h04);
        chk("full_ready_e9", 32'(ready8), 32'd1);
        step(1);                     // e10: stalled code accepted
        av8 = 1'b0;
        chk("full_cnt_e10", 32'(cnt8), 32'd4);
        chk("full_ready_e10", 32'(ready8), 32'd0);

        // Wrap-around on u4: ten codes with random a_valid gaps
        words_seen = 0;
        for (int i = 0; i < 10; i++) begin
            av4 = 1'b0;
            step($urandom_range(0, 3));
            a4 = 3'(codes[i]);
            av4 = 1'b1;
            wait_cnt = 0;
            while (!ready4 && wait_cnt < 100) begin
                step(1);
                wait_cnt++;
            end
            chk("wrap_accept_ready", 32'(ready4), 32'd1);
            exp_q.push_back(8'd1 << codes[i]);
            step(1);
        end
        av4 = 1'b0;
        wait_cnt = 0;
        while ((exp_q.size() != 0 || yv4) && wait_cnt < 200) begin
            step(1);
            wait_cnt++;
        end
        chk("wrap_drained_q", 32'(exp_q.size()), 32'd0);
        chk("wrap_drained_yv", 32'(yv4), 32'd0);
        chk("wrap_words_seen", 32'(words_seen), 32'd10);

        // Reset mid-HOLD with three codes queued on u4
        av4 = 1'b1;
        a4 = 3'd2; exp_q.push_back(8'h04); step(1);
        a4 = 3'd3; exp_q.push_back(8'h08); step(1);
        a4 = 3'd4; exp_q.push_back(8'h10); step(1);
        a4 = 3'd5; exp_q.push_back(8'h20); step(1);
        chk("rmid_cnt", 32'(cnt4), 32'd3);
        chk("rmid_y", 32'(y4), 32'h04);
        chk("rmid_state", 32'(st4), 32'd1);
        rst4_n = 1'b0;
        a4 = 3'd6;                   // offered during reset, must be dropped
        exp_q.delete();
        step(1);
        rst4_n = 1'b1;
        av4 = 1'b0;
        chk("rmid_y_after", 32'(y4), 32'h00);
        chk("rmid_yv_after", 32'(yv4), 32'd0);
        chk("rmid_cnt_after", 32'(cnt4), 32'd0);
        chk("rmid_ready_after", 32'(ready4), 32'd1);
        chk("rmid_state_after", 32'(st4), 32'd0);
        for (int c = 0; c < 12; c++) begin
            step(1);
            chk("rmid_no_stale", 32'(yv4), 32'd0);
        end
        chk("rmid_cnt_final", 32'(cnt4), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
